// File: rtl/game_turn_controller.sv
// Dice-race turn FSM between dice recognition and the UI overlay; pos_valid pulses 2 cycles after an accepted dice strobe.
// No backpressure: strobes outside INTRO/WAIT_DICE/WIN are dropped; WAIT_ANIM waits on turn_done or the timeout.
module game_turn_controller #(
  parameter int FINISH_TILE  = 15,
  parameter int DICE_MAX     = 6,
  parameter int ANIM_TIMEOUT = 2**24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_pulse,
  input  logic       menu_select,
  input  logic       dice_valid,
  input  logic [2:0] dice_value,
  input  logic       turn_done,
  output logic       is_intro_state,
  output logic       dice_ready,
  output logic [3:0] p1_pos,
  output logic [3:0] p2_pos,
  output logic       turn,
  output logic       pos_valid,
  output logic       winner_valid,
  output logic       anim_timeout
);

  localparam int CNT_W = $clog2(ANIM_TIMEOUT + 1);

  typedef enum logic [2:0] {INTRO, WAIT_DICE, MOVE, WAIT_ANIM, WIN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       dice_q, dice_d;
  logic [3:0]       p1_q, p1_d, p2_q, p2_d;
  logic             turn_q, turn_d;
  logic             pos_valid_q, pos_valid_d;
  logic             winner_q, winner_d;
  logic             timeout_q, timeout_d;
  logic             intro_q, intro_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] active_pos;
  logic [4:0] sum;
  logic [3:0] moved;
  logic       done;
  logic       expired;

  always_comb begin
    state_d     = state_q;
    dice_d      = dice_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    turn_d      = turn_q;
    pos_valid_d = 1'b0;
    winner_d    = winner_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    done        = 1'b0;
    expired     = 1'b0;

    active_pos = turn_q ? p2_q : p1_q;
    sum        = {1'b0, active_pos} + {2'b00, dice_q};
    moved      = (sum >= 5'(FINISH_TILE)) ? 4'(FINISH_TILE) : sum[3:0];

    case (state_q)
      INTRO: begin
        if (start_pulse && !menu_select) begin
          p1_d      = '0;
          p2_d      = '0;
          turn_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = WAIT_DICE;
        end
      end
      WAIT_DICE: begin
        if (dice_valid && (dice_value != 3'd0) && (dice_value <= 3'(DICE_MAX))) begin
          dice_d  = dice_value;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (turn_q) p2_d = moved;
        else        p1_d = moved;
        pos_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT_ANIM;
      end
      WAIT_ANIM: begin
        // The renderer cannot have finished on the cycle it is told about the move.
        done    = turn_done && !pos_valid_q;
        expired = (cnt_q == CNT_W'(ANIM_TIMEOUT - 1));
        if (done || expired) begin
          if (!done) timeout_d = 1'b1;
          if (active_pos == 4'(FINISH_TILE)) begin
            winner_d = 1'b1;
            state_d  = WIN;
          end else begin
            turn_d  = ~turn_q;
            state_d = WAIT_DICE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WIN: begin
        if (start_pulse) begin
          winner_d = 1'b0;
          p1_d     = '0;
          p2_d     = '0;
          state_d  = INTRO;
        end
      end
      default: state_d = INTRO;
    endcase

    intro_d = (state_d == INTRO);
    ready_d = (state_d == WAIT_DICE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INTRO;
      dice_q      <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      turn_q      <= 1'b0;
      pos_valid_q <= 1'b0;
      winner_q    <= 1'b0;
      timeout_q   <= 1'b0;
      intro_q     <= 1'b1;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      dice_q      <= dice_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      turn_q      <= turn_d;
      pos_valid_q <= pos_valid_d;
      winner_q    <= winner_d;
      timeout_q   <= timeout_d;
      intro_q     <= intro_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign is_intro_state = intro_q;
  assign dice_ready     = ready_q;
  assign p1_pos         = p1_q;
  assign p2_pos         = p2_q;
  assign turn           = turn_q;
  assign pos_valid      = pos_valid_q;
  assign winner_valid   = winner_q;
  assign anim_timeout   = timeout_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Bench for game_turn_controller: expected moves are queued when dice are driven and matched against pos_valid pulses.
module tb_game_turn_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_pulse = 1'b0;
  logic       menu_select = 1'b0;
  logic       dice_valid = 1'b0;
  logic [2:0] dice_value = 3'd0;
  logic       turn_done = 1'b0;
  logic       is_intro_state, dice_ready, turn, pos_valid, winner_valid, anim_timeout;
  logic [3:0] p1_pos, p2_pos;

  game_turn_controller #(.FINISH_TILE(15), .DICE_MAX(6), .ANIM_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start_pulse(start_pulse), .menu_select(menu_select),
    .dice_valid(dice_valid), .dice_value(dice_value), .turn_done(turn_done),
    .is_intro_state(is_intro_state), .dice_ready(dice_ready), .p1_pos(p1_pos), .p2_pos(p2_pos),
    .turn(turn), .pos_valid(pos_valid), .winner_valid(winner_valid), .anim_timeout(anim_timeout)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0] p1;
    logic [3:0] p2;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] m_p1 = 4'd0, m_p2 = 4'd0;
  logic       m_turn = 1'b0, m_win = 1'b0;

  // Every wait goes through here so each pos_valid pulse is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (pos_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pos_valid_unexpected: got pos_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = exp_q.pop_front();
        if (p1_pos !== e.p1 || p2_pos !== e.p2 || cyc != e.at) begin
          errors++;
          $display("FAIL move_result: got p1=%0d p2=%0d at cycle %0d, required p1=%0d p2=%0d at cycle %0d",
                   p1_pos, p2_pos, cyc, e.p1, e.p2, e.at);
        end
      end
    end
  endtask

  task automatic drive_dice(input logic [2:0] v, input logic accept);
    logic [4:0] s;
    exp_t e;
    dice_valid = 1'b1;
    dice_value = v;
    if (accept) begin
      s = {1'b0, (m_turn ? m_p2 : m_p1)} + {2'b00, v};
      if (s > 5'd15) s = 5'd15;
      if (m_turn) m_p2 = s[3:0];
      else        m_p1 = s[3:0];
      e.p1 = m_p1;
      e.p2 = m_p2;
      e.at = cyc + 2;
      exp_q.push_back(e);
    end
    tick();
    dice_valid = 1'b0;
    dice_value = 3'd0;
  endtask

  task automatic wait_pos_valid();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pos_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pos_valid_timeout: got no pos_valid within 8 cycles, required one");
    end
  endtask

  task automatic model_turn_end();
    if ((m_turn ? m_p2 : m_p1) == 4'd15) m_win = 1'b1;
    else                                 m_turn = ~m_turn;
  endtask

  // Called on the pos_valid cycle; turn_done is held over it (must be ignored) and the next cycle.
  task automatic finish_turn();
    turn_done = 1'b1;
    tick();
    checks++;
    if (turn !== m_turn || dice_ready !== 1'b0) begin
      errors++;
      $display("FAIL turn_done_on_pos_valid: got turn=%b dice_ready=%b, required turn=%b dice_ready=0",
               turn, dice_ready, m_turn);
    end
    tick();
    turn_done = 1'b0;
    model_turn_end();
    checks++;
    if (turn !== m_turn || winner_valid !== m_win || dice_ready !== !m_win) begin
      errors++;
      $display("FAIL turn_handoff: got turn=%b winner=%b dice_ready=%b, required turn=%b winner=%b dice_ready=%b",
               turn, winner_valid, dice_ready, m_turn, m_win, !m_win);
    end
  endtask

  task automatic start_game();
    menu_select = 1'b0;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    m_p1 = 4'd0; m_p2 = 4'd0; m_turn = 1'b0; m_win = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({is_intro_state, dice_ready, p1_pos, p2_pos, turn, pos_valid, winner_valid, anim_timeout} !== 14'b10_0000_0000_0000) begin
      errors++;
      $display("FAIL reset_values: got intro=%b ready=%b p1=%0d p2=%0d turn=%b pv=%b win=%b to=%b, required intro=1 rest 0",
               is_intro_state, dice_ready, p1_pos, p2_pos, turn, pos_valid, winner_valid, anim_timeout);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (is_intro_state !== 1'b1 || dice_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got intro=%b ready=%b, required intro=1 ready=0", is_intro_state, dice_ready);
    end
  endtask

  task automatic test_start();
    menu_select = 1'b1;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    checks++;
    if (is_intro_state !== 1'b1 || dice_ready !== 1'b0) begin
      errors++;
      $display("FAIL menu_end_game: got intro=%b ready=%b, required intro=1 ready=0", is_intro_state, dice_ready);
    end
    start_game();
    checks++;
    if (is_intro_state !== 1'b0 || dice_ready !== 1'b1 || p1_pos !== 4'd0 || p2_pos !== 4'd0 || turn !== 1'b0) begin
      errors++;
      $display("FAIL menu_start_game: got intro=%b ready=%b p1=%0d p2=%0d turn=%b, required intro=0 ready=1 p1=0 p2=0 turn=0",
               is_intro_state, dice_ready, p1_pos, p2_pos, turn);
    end
  endtask

  task automatic test_move_handoff();
    drive_dice(3'd4, 1'b1);
    wait_pos_valid();
    finish_turn();
    drive_dice(3'd3, 1'b1);
    wait_pos_valid();
    checks++;
    if (p1_pos !== 4'd4 || p2_pos !== 4'd3) begin
      errors++;
      $display("FAIL p2_move: got p1=%0d p2=%0d, required p1=4 p2=3", p1_pos, p2_pos);
    end
    finish_turn();
  endtask

  task automatic test_illegal_dice();
    drive_dice(3'd0, 1'b0);
    drive_dice(3'd7, 1'b0);
    tick();
    tick();
    checks++;
    if (dice_ready !== 1'b1 || p1_pos !== m_p1 || p2_pos !== m_p2 || turn !== m_turn) begin
      errors++;
      $display("FAIL illegal_dice: got ready=%b p1=%0d p2=%0d turn=%b, required ready=1 p1=%0d p2=%0d turn=%b",
               dice_ready, p1_pos, p2_pos, turn, m_p1, m_p2, m_turn);
    end
    drive_dice(3'd2, 1'b1);
    wait_pos_valid();
    drive_dice(3'd5, 1'b0);
    turn_done = 1'b1;
    tick();
    turn_done = 1'b0;
    model_turn_end();
    checks++;
    if (p1_pos !== 4'd6 || turn !== m_turn || dice_ready !== 1'b1) begin
      errors++;
      $display("FAIL dice_in_wait_anim: got p1=%0d turn=%b ready=%b, required p1=6 turn=%b ready=1",
               p1_pos, turn, dice_ready, m_turn);
    end
  endtask

  task automatic test_winner();
    logic [2:0] rolls[6] = '{3'd2, 3'd6, 3'd1, 3'd1, 3'd1, 3'd6};
    foreach (rolls[i]) begin
      drive_dice(rolls[i], 1'b1);
      wait_pos_valid();
      finish_turn();
    end
    checks++;
    if (winner_valid !== 1'b1 || turn !== 1'b0 || p1_pos !== 4'd15 || p2_pos !== 4'd7) begin
      errors++;
      $display("FAIL winner: got win=%b turn=%b p1=%0d p2=%0d, required win=1 turn=0 p1=15 p2=7",
               winner_valid, turn, p1_pos, p2_pos);
    end
    drive_dice(3'd3, 1'b0);
    tick();
    tick();
    checks++;
    if (winner_valid !== 1'b1 || p1_pos !== 4'd15 || p2_pos !== 4'd7 || dice_ready !== 1'b0) begin
      errors++;
      $display("FAIL win_frozen: got win=%b p1=%0d p2=%0d ready=%b, required win=1 p1=15 p2=7 ready=0",
               winner_valid, p1_pos, p2_pos, dice_ready);
    end
    menu_select = 1'b1;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    checks++;
    if (is_intro_state !== 1'b1 || winner_valid !== 1'b0 || p1_pos !== 4'd0 || p2_pos !== 4'd0) begin
      errors++;
      $display("FAIL win_to_intro: got intro=%b win=%b p1=%0d p2=%0d, required intro=1 win=0 p1=0 p2=0",
               is_intro_state, winner_valid, p1_pos, p2_pos);
    end
  endtask

  task automatic test_timeout();
    start_game();
    drive_dice(3'd2, 1'b1);
    wait_pos_valid();
    repeat (7) tick();
    turn_done = 1'b1;
    tick();
    turn_done = 1'b0;
    checks++;
    if (turn !== 1'b1 || anim_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_coincide: got turn=%b anim_timeout=%b, required turn=1 anim_timeout=0", turn, anim_timeout);
    end
    m_turn = 1'b1;
    drive_dice(3'd5, 1'b1);
    wait_pos_valid();
    repeat (7) tick();
    checks++;
    if (turn !== 1'b1 || anim_timeout !== 1'b0 || dice_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got turn=%b anim_timeout=%b ready=%b, required turn=1 anim_timeout=0 ready=0",
               turn, anim_timeout, dice_ready);
    end
    tick();
    m_turn = 1'b0;
    checks++;
    if (turn !== 1'b0 || anim_timeout !== 1'b1 || dice_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_expire: got turn=%b anim_timeout=%b ready=%b, required turn=0 anim_timeout=1 ready=1",
               turn, anim_timeout, dice_ready);
    end
  endtask

  task automatic test_reset_midop();
    drive_dice(3'd3, 1'b1);
    wait_pos_valid();
    tick();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({is_intro_state, dice_ready, p1_pos, p2_pos, turn, pos_valid, winner_valid, anim_timeout} !== 14'b10_0000_0000_0000) begin
      errors++;
      $display("FAIL async_reset: got intro=%b ready=%b p1=%0d p2=%0d turn=%b pv=%b win=%b to=%b, required intro=1 rest 0",
               is_intro_state, dice_ready, p1_pos, p2_pos, turn, pos_valid, winner_valid, anim_timeout);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    m_p1 = 4'd0; m_p2 = 4'd0; m_turn = 1'b0; m_win = 1'b0;
    checks++;
    if (is_intro_state !== 1'b1 || dice_ready !== 1'b0 || p1_pos !== 4'd0 || anim_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop_release: got intro=%b ready=%b p1=%0d to=%b, required intro=1 ready=0 p1=0 to=0",
               is_intro_state, dice_ready, p1_pos, anim_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_move_handoff();
    test_illegal_dice();
    test_winner();
    test_timeout();
    test_reset_midop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d unmatched moves, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
